ipml_sfifo_v2_0: RTL
====================

IPML_SFIFO_V2_0 -- requirements
Module: ipml_sfifo_v2_0

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk and rst_n, with all state on clk rising edge.
REQ-002 Parameters SHALL be, one per line:
- c_DATA_WIDTH, 32, data width, legal 1..1152
- c_DEPTH_WIDTH, 10, log2 of capacity, legal 4..20, capacity = 2^c_DEPTH_WIDTH words
- c_FWFT, 0, read mode: 0 standard, 1 first-word-fall-through
- c_AF_RESET, 2^c_DEPTH_WIDTH-4, af_thresh value used while rst_n low (documentation only; the threshold is a port)
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- rst_n, in, 1, async active-low reset
- flush, in, 1, synchronous clear
- wr_en, in, 1, write request
- wr_data, in, c_DATA_WIDTH, write word
- rd_en, in, 1, read request or pop
- rd_data, out, c_DATA_WIDTH, read word
- full, out, 1, no space
- empty, out, 1, no readable word
- almost_full, out, 1, level >= af_thresh
- almost_empty, out, 1, level <= ae_thresh
- af_thresh, in, c_DEPTH_WIDTH+1, runtime almost-full threshold
- ae_thresh, in, c_DEPTH_WIDTH+1, runtime almost-empty threshold
- water_level, out, c_DEPTH_WIDTH+1, stored word count
- overflow, out, 1, sticky write-while-full flag
- underflow, out, 1, sticky read-while-empty flag

Function
REQ-004 Storage SHALL be an inferred simple-dual-port RAM of 2^c_DEPTH_WIDTH x c_DATA_WIDTH, addressed by c_DEPTH_WIDTH-bit write and read pointers that wrap modulo 2^c_DEPTH_WIDTH.
REQ-005 A write SHALL be accepted when wr_en=1 and full=0. An accepted write stores wr_data at the write pointer and increments it.
REQ-006 A write with full=1 SHALL be dropped and SHALL set overflow. This holds even if rd_en=1 in the same cycle.
REQ-007 A read SHALL be accepted when rd_en=1 and empty=0. A read with empty=1 SHALL be ignored, SHALL set underflow, and SHALL leave rd_data unchanged.
REQ-008 Standard mode (c_FWFT=0): for a read accepted at edge N, rd_data SHALL present the word after edge N (1-cycle latency). rd_data SHALL hold its value when no read is accepted.
REQ-009 FWFT mode (c_FWFT=1): the head word SHALL be held in an output register. Whenever empty=0, rd_data SHALL equal the head word. An accepted rd_en pops the head word, and the next word SHALL appear after the same edge if one is stored.
REQ-010 FWFT prefetch: after a write at edge N into a FIFO with water_level=0, empty SHALL fall and rd_data SHALL be valid after edge N+1. In standard mode, empty SHALL fall after edge N.
REQ-011 water_level SHALL count all stored words, including the FWFT output-register word, in the range 0..2^c_DEPTH_WIDTH.
- The level changes by +1 on an accepted write only, -1 on an accepted read only, and 0 when both are accepted.
REQ-012 full, empty, almost_full, almost_empty, water_level, overflow and underflow SHALL all be registered. Each SHALL reflect the post-edge state, so there is no combinational path from wr_en or rd_en.
- full = (level == 2^c_DEPTH_WIDTH).
- almost_full = (level >= af_thresh).
- almost_empty = (level <= ae_thresh), compared unsigned.
REQ-013 A threshold change SHALL take effect on the flags at the next edge.
REQ-014 Simultaneous write and read at full: the write SHALL be dropped and the read accepted, giving level 2^c_DEPTH_WIDTH-1 and overflow=1.
REQ-015 Simultaneous write and read at empty: the write SHALL be accepted and the read ignored, with underflow set.
REQ-016 flush=1 SHALL have priority over wr_en and rd_en and SHALL, at that edge:
- zero both pointers and the level;
- set empty and almost_empty (when ae_thresh >= 0);
- clear full, almost_full, overflow and underflow;
- invalidate the FWFT output register.
rd_data and the RAM contents SHALL NOT be cleared by flush.
REQ-017 overflow and underflow SHALL remain set until flush or reset.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously clear pointers, level and flags:
- water_level=0, empty=1, almost_empty=1, full=0, almost_full=0 (almost_full=1 only if af_thresh=0), overflow=0, underflow=0, rd_data=0.
REQ-019 On rst_n release, the first accepted operation SHALL occur at the first edge with rst_n=1. The user SHALL synchronise the release externally.
REQ-020 A reset mid-operation SHALL discard all stored words. No read after reset SHALL return pre-reset data.

Verification (c_DEPTH_WIDTH=4, c_DATA_WIDTH=8, af_thresh=14, ae_thresh=2)
REQ-021 Fill: write 0x00..0x0F on 16 consecutive cycles, then write 0xAA.
- Expected: almost_full=1 after the 14th write, full=1 after the 16th.
- Expected: 0xAA dropped, overflow=1, water_level=16.
REQ-022 Drain, standard mode: from full, assert rd_en for 17 cycles.
- Expected: rd_data=0x00..0x0F, each 1 cycle after its accept.
- Expected: empty=1 after the 16th read; the 17th read sets underflow=1 and rd_data stays 0x0F.
REQ-023 FWFT: write 0x5C to an empty FIFO at edge N.
- Expected: empty=0 and rd_data=0x5C after edge N+1; rd_en=1 then gives empty=1 and water_level=0.
REQ-024 Wrap-around: run 40 cycles of simultaneous write and read at level 8 with an incrementing pattern.
- Expected: level stays 8, data is in order with no loss, and the pointers wrap twice.
REQ-025 Flush and reset: at level 9 with overflow=1, pulse flush together with wr_en=1.
- Expected: level=0, empty=1, overflow=0, and the write is dropped.
- Then refill 5 words and assert rst_n=0 mid-cycle: all flags return to reset values immediately, with no clock edge needed.
REQ-026 Threshold change: at level 5, set ae_thresh=5.
- Expected: almost_empty=1 after the next edge; setting af_thresh=5 also gives almost_full=1.

Source files
------------

// File: rtl/ipml_sfifo_v2_0.sv
// Synchronous FIFO on an inferred simple-dual-port RAM. It has a standard read mode
// and a first-word-fall-through read mode, runtime watermarks, and sticky error flags.
module ipml_sfifo_v2_0 #(
  parameter int unsigned c_DATA_WIDTH  = 32,
  parameter int unsigned c_DEPTH_WIDTH = 10,
  parameter int unsigned c_FWFT        = 0,
  parameter int unsigned c_AF_RESET    = (1 << c_DEPTH_WIDTH) - 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     rd_en,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  input  logic [c_DEPTH_WIDTH:0]   af_thresh,
  input  logic [c_DEPTH_WIDTH:0]   ae_thresh,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned LP_CAP = 1 << c_DEPTH_WIDTH;
  localparam logic [c_DEPTH_WIDTH:0] LP_FULL = {1'b1, {c_DEPTH_WIDTH{1'b0}}};

  if (c_FWFT > 1 || c_DEPTH_WIDTH < 4 || c_DEPTH_WIDTH > 20 || c_DATA_WIDTH < 1 ||
      c_DATA_WIDTH > 1152 || c_AF_RESET > LP_CAP) begin : g_param_check
    $error("ipml_sfifo_v2_0: illegal parameter value");
  end

  logic [c_DATA_WIDTH-1:0]  r_mem [0:LP_CAP-1];
  logic [c_DEPTH_WIDTH-1:0] r_wptr, r_rptr;
  logic [c_DEPTH_WIDTH:0]   r_level;
  logic [c_DATA_WIDTH-1:0]  r_rd_data;
  logic r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_ovalid, r_run;

  logic                     w_wr_acc, w_rd_acc, w_load, w_ovalid_nxt;
  logic [c_DEPTH_WIDTH:0]   w_level_nxt, w_ram_cnt;

  always_comb begin
    w_wr_acc    = wr_en & ~r_full & ~flush;
    w_rd_acc    = rd_en & ~r_empty & ~flush;
    w_level_nxt = r_level + {{c_DEPTH_WIDTH{1'b0}}, w_wr_acc}
                          - {{c_DEPTH_WIDTH{1'b0}}, w_rd_acc};
    // words still in RAM, i.e. not yet moved into the FWFT output register
    w_ram_cnt   = r_level - {{c_DEPTH_WIDTH{1'b0}}, r_ovalid};
    if (c_FWFT != 0) begin
      w_load       = (w_ram_cnt != '0) & (~r_ovalid | w_rd_acc) & ~flush;
      w_ovalid_nxt = w_load | (r_ovalid & ~w_rd_acc);
    end else begin
      w_load       = w_rd_acc;
      w_ovalid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_af      <= 1'b0;
      r_ae      <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_ovalid  <= 1'b0;
      r_run     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_level  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
        r_af     <= 1'b0;
        r_ae     <= 1'b1;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
        r_ovalid <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
        if (w_load) begin
          r_rptr    <= r_rptr + 1'b1;
          r_rd_data <= r_mem[r_rptr];
        end
        r_level  <= w_level_nxt;
        r_ovalid <= w_ovalid_nxt;
        r_full   <= (w_level_nxt == LP_FULL);
        r_empty  <= (c_FWFT != 0) ? ~w_ovalid_nxt : (w_level_nxt == '0);
        r_af     <= (w_level_nxt >= af_thresh);
        r_ae     <= (w_level_nxt <= ae_thresh);
        if (wr_en & r_full)  r_ovf <= 1'b1;
        if (rd_en & r_empty) r_udf <= 1'b1;
      end
    end
  end

  // Until the first edge after reset, a zero threshold must already read as almost full
  assign almost_full  = r_af | (~r_run & (af_thresh == '0));
  assign rd_data      = r_rd_data;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_empty = r_ae;
  assign water_level  = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
